// File: rtl/imm_inst_encoder.sv
// Purpose : packs a 64-bit signed byte offset plus register/funct3 fields into
//           RV64 load/store words. Immediates that fit 12 bits give one word;
//           wider ones expand to LUI/ADD/mem through a scratch register.
// Latency : first beat is registered, valid the cycle after acceptance. A
//           long-form request emits three beats, one per consumed cycle.
// Backpres: out_* hold while out_valid && !out_ready. in_ready is high only
//           when idle or while the final beat is being consumed. This keeps
//           the short form at one request per cycle.
// Ports   : clk, rst_n (async, active-low)
//           in_valid/in_ready plus in_store, in_rd, in_rs1, in_rs2,
//           in_funct3 and in_imm form the request stream.
//           out_valid/out_ready plus out_inst, out_last and out_err form the
//           instruction beat stream.
// Config  : define IMM_LONG_FORM_EN to enable the LUI/ADD/mem expansion and
//           the TMP_REG parameter. Without it, every immediate that does not
//           fit 12 bits becomes an error NOP beat.
module imm_inst_encoder
`ifdef IMM_LONG_FORM_EN
  #(parameter logic [4:0] TMP_REG = 5'd5)
`endif
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_store,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [63:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_last,
  output logic        out_err
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD_LAST
`ifdef IMM_LONG_FORM_EN
    ,
    S_EMIT_LUI,
    S_EMIT_ADD,
    S_EMIT_MEM
`endif
  } state_e;

  state_e      state_q, new_state;
  logic        out_valid_q, out_last_q, out_err_q;
  logic [31:0] out_inst_q;
  logic        accept, is_short;
  logic [31:0] new_inst;
  logic        new_last, new_err;

  function automatic logic [31:0] enc_mem(input logic st, input logic [4:0] rd,
                                          input logic [4:0] base, input logic [4:0] rs2,
                                          input logic [2:0] f3, input logic [11:0] off);
    enc_mem = st ? {off[11:5], rs2, base, f3, off[4:0], 7'b0100011}
                 : {off, base, f3, rd, 7'b0000011};
  endfunction

`ifdef IMM_LONG_FORM_EN
  // The upper bound leaves room for the +1 carry from imm[11], so hi never
  // wraps into a negative LUI value.
  localparam logic signed [63:0] LONG_MIN = -64'sd2147483648;
  localparam logic signed [63:0] LONG_MAX = 64'sd2147481599;

  logic        is_long;
  logic [19:0] new_hi;
  logic        st_q;
  logic [4:0]  rd_q, rs1_q, rs2_q;
  logic [2:0]  f3_q;
  logic [11:0] lo_q;

  assign new_hi  = in_imm[31:12] + {19'b0, in_imm[11]};
  // The mem op uses TMP_REG as its base, so a store cannot also source
  // its data from TMP_REG.
  assign is_long = !is_short
                && ($signed(in_imm) >= LONG_MIN) && ($signed(in_imm) <= LONG_MAX)
                && !(in_store && (in_rs2 == TMP_REG));
`endif

  // in_ready is gated by out_last. Mid-sequence beats therefore never admit
  // a new request.
  assign in_ready = !out_valid_q || (out_ready && out_last_q);
  assign accept   = in_valid && in_ready;
  assign is_short = (&in_imm[63:11]) || (~|in_imm[63:11]);

  always_comb begin
    new_inst  = NOP;
    new_last  = 1'b1;
    new_err   = 1'b1;
    new_state = S_HOLD_LAST;
    if (is_short) begin
      new_inst = enc_mem(in_store, in_rd, in_rs1, in_rs2, in_funct3, in_imm[11:0]);
      new_err  = 1'b0;
    end
`ifdef IMM_LONG_FORM_EN
    else if (is_long) begin
      new_inst  = {new_hi, TMP_REG, 7'b0110111};
      new_last  = 1'b0;
      new_err   = 1'b0;
      new_state = S_EMIT_LUI;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_last_q  <= 1'b0;
      out_err_q   <= 1'b0;
`ifdef IMM_LONG_FORM_EN
      st_q  <= 1'b0;
      rd_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      f3_q  <= '0;
      lo_q  <= '0;
`endif
    end else if (accept) begin
      // Acceptance only happens when idle or as the last beat is consumed,
      // so a new request is loaded directly over the finished one.
      state_q     <= new_state;
      out_valid_q <= 1'b1;
      out_inst_q  <= new_inst;
      out_last_q  <= new_last;
      out_err_q   <= new_err;
`ifdef IMM_LONG_FORM_EN
      st_q  <= in_store;
      rd_q  <= in_rd;
      rs1_q <= in_rs1;
      rs2_q <= in_rs2;
      f3_q  <= in_funct3;
      lo_q  <= in_imm[11:0];
`endif
    end else if (out_ready) begin
      case (state_q)
`ifdef IMM_LONG_FORM_EN
        S_EMIT_LUI: begin
          out_inst_q <= {7'b0, rs1_q, TMP_REG, 3'b000, TMP_REG, 7'b0110011};
          state_q    <= S_EMIT_ADD;
        end
        S_EMIT_ADD: begin
          out_inst_q <= enc_mem(st_q, rd_q, TMP_REG, rs2_q, f3_q, lo_q);
          out_last_q <= 1'b1;
          state_q    <= S_EMIT_MEM;
        end
        S_EMIT_MEM,
`endif
        S_HOLD_LAST: begin
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
          out_err_q   <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_last  = out_last_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_imm_inst_encoder.sv
module tb_imm_inst_encoder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_store;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [63:0] in_imm;
  logic        out_valid, out_ready, out_last, out_err;
  logic [31:0] out_inst;

  always #5 clk = ~clk;

  imm_inst_encoder dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_store(in_store),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_last(out_last), .out_err(out_err)
  );

  typedef struct { logic [31:0] inst; logic last; logic err; } beat_t;
  beat_t       exp_q[$];
  beat_t       popped[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        hold_pend = 1'b0;
  logic [31:0] hold_inst;
  logic        acc_flag;
`ifdef IMM_LONG_FORM_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference encoder: plain field arithmetic on integers.
  function automatic logic [31:0] ref_mem(bit st, longint rd, longint base, longint rs2,
                                          longint f3, longint off);
    longint u, w;
    u = off & 'hFFF;
    if (st) w = ((u >> 5) << 25) | (rs2 << 20) | (base << 15) | (f3 << 12) | ((u & 31) << 7) | 'h23;
    else    w = (u << 20) | (base << 15) | (f3 << 12) | (rd << 7) | 'h03;
    return w[31:0];
  endfunction

  task automatic model_push(bit st, longint rd, longint rs1, longint rs2, longint f3,
                            logic [63:0] imm);
    longint s, lo, hi, w;
    s = imm;
    if (s >= -2048 && s <= 2047) begin
      exp_q.push_back('{ref_mem(st, rd, rs1, rs2, f3, s), 1'b1, 1'b0});
    end else if (LONG_EN && s >= -64'sd2147483648 && s <= 64'sd2147481599 && !(st && rs2 == 5)) begin
      lo = s & 'hFFF;
      if (lo >= 2048) lo = lo - 4096;
      hi = (s - lo) / 4096;
      w  = ((hi & 'hFFFFF) << 12) | (5 << 7) | 'h37;
      exp_q.push_back('{w[31:0], 1'b0, 1'b0});
      w  = (rs1 << 20) | (5 << 15) | (5 << 7) | 'h33;
      exp_q.push_back('{w[31:0], 1'b0, 1'b0});
      exp_q.push_back('{ref_mem(st, rd, 5, rs2, f3, lo), 1'b1, 1'b0});
    end else begin
      exp_q.push_back('{32'h0000_0013, 1'b1, 1'b1});
    end
  endtask

  // One clock with scoreboard checks done at the falling edge.
  task automatic step();
    beat_t b;
    logic  exp_rdy;
    @(negedge clk);
    check("valid", out_valid, exp_q.size() != 0);
    exp_rdy = (exp_q.size() == 0) || (out_ready && exp_q[0].last);
    check("in_ready", in_ready, exp_rdy);
    if (out_valid && hold_pend) check("stable", out_inst, hold_inst);
    if (out_valid && out_ready && exp_q.size() != 0) begin
      b = exp_q.pop_front();
      popped.push_back(b);
      check("inst", out_inst, b.inst);
      check("last", out_last, b.last);
      check("err", out_err, b.err);
    end
    hold_pend = out_valid && !out_ready;
    hold_inst = out_inst;
    acc_flag  = in_valid && in_ready;
    if (acc_flag) model_push(in_store, in_rd, in_rs1, in_rs2, in_funct3, in_imm);
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    in_store  = 1'($urandom);
    in_rd     = 5'($urandom);
    in_rs1    = 5'($urandom);
    in_rs2    = 5'($urandom);
    in_funct3 = 3'($urandom);
    in_imm    = {$urandom, $urandom};
  endtask

  task automatic send(input bit st, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [63:0] imm);
    bit ok = 0;
    in_store = st; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_funct3 = f3; in_imm = imm;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (acc_flag) begin ok = 1; break; end
    end
    if (!ok) check("send_timeout", 0, 1);
    in_valid = 1'b0;
    scramble();  // later input changes must not disturb the captured request
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      step();
    end
    if (exp_q.size() != 0 || out_valid) check("drain_timeout", 0, 1);
  endtask

  function automatic logic [63:0] pick_imm();
    longint tbl[10];
    tbl = '{-2048, 2047, 2048, -2049, 64'sd2147481599, 64'sd2147481600,
            -64'sd2147483648, -64'sd2147483649, 4096, 64'h1_0000_0000};
    case ($urandom_range(0, 4))
      0: return longint'($urandom_range(0, 4095)) - 2048;
      1: return tbl[$urandom_range(0, 9)];
      2: return longint'(int'($urandom));
      3: return {$urandom, $urandom};
      default: return longint'($urandom_range(0, 8191)) - 4096;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    scramble();
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_inst", out_inst, 0);
    check("rst_last", out_last, 0);
    check("rst_err", out_err, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // ld a0,-8(sp)
    out_ready = 1'b1; popped.delete();
    send(0, 10, 2, 0, 3, -64'sd8); drain();
    check("ld_beats", popped.size(), 1);
    if (popped.size() > 0) check("ld_inst", popped[0].inst, 32'hFF81_3503);
    // sd a1,16(sp)
    popped.delete();
    send(1, 0, 2, 11, 3, 64'd16); drain();
    check("sd_beats", popped.size(), 1);
    if (popped.size() > 0) check("sd_inst", popped[0].inst, 32'h00B1_3823);

    // Long immediate with a three-cycle stall on its first beat
    popped.delete();
    send(0, 10, 2, 0, 3, 64'h1234_5FFF);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_in_ready", in_ready, 0);
    end
    check("stall_inst", out_inst, LONG_EN ? 32'h1234_62B7 : 32'h0000_0013);
    drain();
    if (LONG_EN) begin
      check("long_beats", popped.size(), 3);
      if (popped.size() == 3) begin
        check("long_b0", {popped[0].inst, 7'b0, popped[0].last}, {32'h1234_62B7, 8'd0});
        check("long_b1", {popped[1].inst, 7'b0, popped[1].last}, {32'h0022_82B3, 8'd0});
        check("long_b2", {popped[2].inst, 7'b0, popped[2].last}, {32'hFFF2_B503, 8'd1});
      end
    end else begin
      check("long_beats", popped.size(), 1);
      if (popped.size() > 0) check("long_err", {popped[0].inst, 7'b0, popped[0].err}, {32'h13, 8'd1});
    end

    // Unencodable requests
    popped.delete();
    send(0, 10, 2, 0, 3, 64'h1_0000_0000);
    send(1, 0, 2, 5, 3, 64'd4096);
    drain();
    check("err_beats", popped.size(), 2);
    for (int i = 0; i < 2 && i < popped.size(); i++)
      check("err_beat", {popped[i].inst, 6'b0, popped[i].last, popped[i].err}, {32'h13, 8'd3});

    // Back-to-back short requests: one accepted every cycle
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_store = 1'($urandom); in_rd = 5'(i + 1); in_rs1 = 5'd2; in_rs2 = 5'd9;
      in_funct3 = 3'd2; in_imm = longint'(i * 100) - 150;
      step();
      check("b2b_accept", acc_flag, 1);
    end
    drain();

    // Reset while the ADD beat (or, in the default build, the only beat) is pending
    send(0, 10, 2, 0, 3, 64'h1234_5FFF);
    if (LONG_EN) step();
    out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_inst", out_inst, 0);
    exp_q.delete(); hold_pend = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    popped.delete();
    out_ready = 1'b1;
    send(0, 10, 2, 0, 3, -64'sd8); drain();
    check("post_rst_beats", popped.size(), 1);
    if (popped.size() > 0) check("post_rst_inst", popped[0].inst, 32'hFF81_3503);

    // Randomized traffic with random backpressure
    for (int c = 0; c < 800; c++) begin
      in_valid  = ($urandom_range(0, 9) < 6);
      scramble();
      if ($urandom_range(0, 7) == 0) in_rs2 = 5'd5;
      in_imm    = pick_imm();
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    drain();
    check("final_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
